// File: rtl/cpu_hatch_arbiter.sv
// cpu_hatch_arbiter: shares the single instruction-memory ("hatch") port
// between the fetch stage and the program loader/debug requester.
// Fetch wins by default. A run counter guarantees the loader a slot after
// MAX_RUN consecutive fetch grants. load_lock lets the loader hold the port
// for bursts. Read responses (1-cycle latency) are routed back by a tag.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fetch_req/addr           fetch read request, byte address
//   fetch_gnt/stall          same-cycle grant / stall (combinational)
//   fetch_rvalid/rdata       fetch read response
//   load_req/we/lock/addr/wdata  loader request
//   load_gnt                 same-cycle loader grant (combinational)
//   load_rvalid/rdata        loader read response
//   mem_en/we/addr/wdata     memory command
//   mem_rdata                memory read data, valid the cycle after a read
module cpu_hatch_arbiter #(
    parameter int unsigned AW      = 10,
    parameter int unsigned MAX_RUN = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_gnt,
    output logic          fetch_stall,
    output logic          fetch_rvalid,
    output logic [47:0]   fetch_rdata,
    input  logic          load_req,
    input  logic          load_we,
    input  logic          load_lock,
    input  logic [31:0]   load_addr,
    input  logic [47:0]   load_wdata,
    output logic          load_gnt,
    output logic          load_rvalid,
    output logic [47:0]   load_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [47:0]   mem_wdata,
    input  logic [47:0]   mem_rdata
);

    localparam int unsigned DW = 48;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        OWN_FREE   = 2'd0,
        OWN_FETCH  = 2'd1,
        OWN_LOCKED = 2'd2
    } owner_t;

    owner_t        owner;
    logic [CW-1:0] run_cnt;
    logic          rd_pend_fetch;
    logic          rd_pend_load;
    logic [DW-1:0] fetch_hold;
    logic [DW-1:0] load_hold;
    logic          run_full;

    assign run_full = (run_cnt == CW'(MAX_RUN));

    // Grant selection; rst only masks, state itself is registered.
    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (!rst) begin
            if (owner == OWN_LOCKED) begin
                load_gnt = load_req;
            end else if (load_req && (!fetch_req || run_full)) begin
                load_gnt = 1'b1;
            end else if (fetch_req) begin
                fetch_gnt = 1'b1;
            end
        end
    end

    assign fetch_stall = fetch_req & ~fetch_gnt;

    // Memory command muxed from the granted requester; idle address is zero.
    always_comb begin
        mem_addr = '0;
        if (load_gnt) begin
            mem_addr = load_addr[AW+1:2];
        end else if (fetch_gnt) begin
            mem_addr = fetch_addr[AW+1:2];
        end
    end

    assign mem_en    = fetch_gnt | load_gnt;
    assign mem_we    = load_gnt & load_we;
    assign mem_wdata = load_wdata;

    // Owner FSM, starvation counter and response tags.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner         <= OWN_FREE;
            run_cnt       <= '0;
            rd_pend_fetch <= 1'b0;
            rd_pend_load  <= 1'b0;
            fetch_hold    <= '0;
            load_hold     <= '0;
        end else begin
            if (load_gnt || !load_req) begin
                run_cnt <= '0;
            end else if (fetch_gnt && !run_full) begin
                run_cnt <= run_cnt + CW'(1);
            end

            if (load_gnt && load_lock) begin
                owner <= OWN_LOCKED;
            end else begin
                case (owner)
                    OWN_LOCKED: if (!load_lock) owner <= OWN_FREE;
                    OWN_FREE:   if (fetch_gnt)  owner <= OWN_FETCH;
                    OWN_FETCH:  if (!fetch_req) owner <= OWN_FREE;
                    default:    owner <= OWN_FREE;
                endcase
            end

            rd_pend_fetch <= fetch_gnt;
            rd_pend_load  <= load_gnt & ~load_we;

            // Capture delivered data so the idle requester's rdata stays put.
            if (rd_pend_fetch) fetch_hold <= mem_rdata;
            if (rd_pend_load)  load_hold  <= mem_rdata;
        end
    end

    assign fetch_rvalid = rd_pend_fetch;
    assign load_rvalid  = rd_pend_load;
    assign fetch_rdata  = rd_pend_fetch ? mem_rdata : fetch_hold;
    assign load_rdata   = rd_pend_load  ? mem_rdata : load_hold;

    // Address bits outside the word index are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{fetch_addr, load_addr};

endmodule
